// File: rtl/alu.sv
// Registered N-bit ALU: eight ops selected by op_code, with result, carry and zero
// captured on the rising edge when en is high. Synchronous active-high reset.
module alu #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   op_code,
    input  logic         en,
    output logic [N-1:0] result_out,
    output logic         flag_carry,
    output logic         flag_zero
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_NOT = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_e;

    typedef struct packed {
        logic         carry;
        logic [N-1:0] res;
    } alu_rsp_t;

    alu_rsp_t     nxt;
    logic [N:0]   sum;
    logic [N:0]   diff;

    // One extra bit on add/sub exposes carry-out and borrow directly.
    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = {1'b0, A} - {1'b0, B};

    always_comb begin
        nxt = '0;
        case (op_e'(op_code))
            OP_ADD: nxt = {sum[N], sum[N-1:0]};
            OP_SUB: nxt = {diff[N], diff[N-1:0]};
            OP_AND: nxt.res = A & B;
            OP_NOT: nxt.res = ~A;
            OP_OR:  nxt.res = A | B;
            OP_XOR: nxt.res = A ^ B;
            OP_SHL: nxt = {A[N-1], A[N-2:0], 1'b0};
            OP_SHR: nxt = {A[0], 1'b0, A[N-1:1]};
            default: nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_out <= '0;
            flag_carry <= 1'b0;
            flag_zero  <= 1'b0;
        end else if (en) begin
            result_out <= nxt.res;
            flag_carry <= nxt.carry;
            flag_zero  <= (nxt.res == '0);
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu (N=8): an integer reference model feeds a scoreboard
// queue at drive time; each test task pops and compares after the capturing edge.
module tb_alu;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] A, B;
    logic [2:0] op_code;
    logic       en;
    logic [7:0] result_out;
    logic       flag_carry;
    logic       flag_zero;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] r;
        logic       c;
        logic       z;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    alu #(.N(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .B          (B),
        .op_code    (op_code),
        .en         (en),
        .result_out (result_out),
        .flag_carry (flag_carry),
        .flag_zero  (flag_zero)
    );

    always #5 clk = ~clk;

    // Reference model in plain integer arithmetic.
    function automatic exp_t model(input int op, input int a, input int b);
        exp_t e;
        int   r;
        e.c = 1'b0;
        r   = 0;
        case (op)
            0: begin r = (a + b) % 256; e.c = ((a + b) > 255); end
            1: begin r = (a - b + 256) % 256; e.c = (a < b); end
            2: r = a & b;
            3: r = 255 - a;
            4: r = a | b;
            5: r = a ^ b;
            6: begin r = (a * 2) % 256; e.c = (a >= 128); end
            default: begin r = a / 2; e.c = (a % 2 == 1); end
        endcase
        e.r = r[7:0];
        e.z = (r == 0);
        return e;
    endfunction

    // Drive on negedge, push expectation, step past the capturing edge.
    task automatic drive(input logic r, input logic e, input int op, input int a, input int b);
        @(negedge clk);
        rst     = r;
        en      = e;
        op_code = op[2:0];
        A       = a[7:0];
        B       = b[7:0];
        if (r) begin
            cur.r = 8'd0; cur.c = 1'b0; cur.z = 1'b0;
        end else if (e) begin
            cur = model(op, a, b);
        end
        sb.push_back(cur);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t x;
        drive(1, 0, 0, 0, 0);
        x = sb.pop_front();
        vectors++;
        if ({result_out, flag_carry, flag_zero} !== {x.r, x.c, x.z}) begin
            miscompares++;
            $display("FAIL reset: got r=%0d c=%b z=%b want r=%0d c=%b z=%b",
                     result_out, flag_carry, flag_zero, x.r, x.c, x.z);
        end
    endtask

    task automatic test_add();
        int va[4] = '{250, 255, 0, 100};
        int vb[4] = '{6, 255, 0, 27};
        exp_t x;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, va[i], vb[i]);
            x = sb.pop_front();
            vectors++;
            if ({result_out, flag_carry, flag_zero} !== {x.r, x.c, x.z}) begin
                miscompares++;
                $display("FAIL add[%0d]: got r=%0d c=%b z=%b want r=%0d c=%b z=%b",
                         i, result_out, flag_carry, flag_zero, x.r, x.c, x.z);
            end
        end
    endtask

    task automatic test_sub();
        int va[4] = '{2, 3, 200, 0};
        int vb[4] = '{3, 3, 1, 255};
        exp_t x;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, va[i], vb[i]);
            x = sb.pop_front();
            vectors++;
            if ({result_out, flag_carry, flag_zero} !== {x.r, x.c, x.z}) begin
                miscompares++;
                $display("FAIL sub[%0d]: got r=%0d c=%b z=%b want r=%0d c=%b z=%b",
                         i, result_out, flag_carry, flag_zero, x.r, x.c, x.z);
            end
        end
    endtask

    task automatic test_logic();
        int vo[6] = '{2, 3, 4, 5, 2, 5};
        int va[6] = '{23, 25, 8'h0F, 15, 8'hAA, 8'h5A};
        int vb[6] = '{20, 77, 8'hF0, 3, 8'h55, 8'h5A};
        exp_t x;
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, vo[i], va[i], vb[i]);
            x = sb.pop_front();
            vectors++;
            if ({result_out, flag_carry, flag_zero} !== {x.r, x.c, x.z}) begin
                miscompares++;
                $display("FAIL logic[%0d] op=%0d: got r=%0d c=%b z=%b want r=%0d c=%b z=%b",
                         i, vo[i], result_out, flag_carry, flag_zero, x.r, x.c, x.z);
            end
        end
    endtask

    task automatic test_shift();
        int vo[5] = '{6, 7, 7, 6, 7};
        int va[5] = '{8'h81, 8'h81, 8'h01, 8'h40, 8'h80};
        exp_t x;
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, vo[i], va[i], 8'hFF);
            x = sb.pop_front();
            vectors++;
            if ({result_out, flag_carry, flag_zero} !== {x.r, x.c, x.z}) begin
                miscompares++;
                $display("FAIL shift[%0d] op=%0d: got r=%0d c=%b z=%b want r=%0d c=%b z=%b",
                         i, vo[i], result_out, flag_carry, flag_zero, x.r, x.c, x.z);
            end
        end
    endtask

    task automatic test_enable_hold();
        exp_t x;
        drive(0, 1, 0, 200, 100);
        for (int i = 0; i < 5; i++) begin
            if (i >= 1 && i <= 3) drive(0, 0, i + 1, 17 * i, 3 * i);
            else if (i == 4)      drive(0, 1, 5, 8'hF0, 8'h0F);
            x = sb.pop_front();
            vectors++;
            if ({result_out, flag_carry, flag_zero} !== {x.r, x.c, x.z}) begin
                miscompares++;
                $display("FAIL hold[%0d]: got r=%0d c=%b z=%b want r=%0d c=%b z=%b",
                         i, result_out, flag_carry, flag_zero, x.r, x.c, x.z);
            end
        end
    endtask

    task automatic test_reset_priority();
        exp_t x;
        drive(0, 1, 5, 8'h12, 8'h34);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) drive(1, 1, 0, 250, 6);
            else if (i == 2) drive(0, 1, 0, 250, 6);
            x = sb.pop_front();
            vectors++;
            if ({result_out, flag_carry, flag_zero} !== {x.r, x.c, x.z}) begin
                miscompares++;
                $display("FAIL rst_prio[%0d]: got r=%0d c=%b z=%b want r=%0d c=%b z=%b",
                         i, result_out, flag_carry, flag_zero, x.r, x.c, x.z);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t x;
        int op, a, b;
        for (int i = 0; i < 48; i++) begin
            op = i % 8;
            a  = $urandom_range(0, 255);
            b  = $urandom_range(0, 255);
            drive(0, ($urandom_range(0, 3) != 0), op, a, b);
            x = sb.pop_front();
            vectors++;
            if ({result_out, flag_carry, flag_zero} !== {x.r, x.c, x.z}) begin
                miscompares++;
                $display("FAIL b2b[%0d] op=%0d a=%0d b=%0d: got r=%0d c=%b z=%b want r=%0d c=%b z=%b",
                         i, op, a, b, result_out, flag_carry, flag_zero, x.r, x.c, x.z);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; op_code = 3'd0; A = 8'd0; B = 8'd0;
        cur.r = 8'd0; cur.c = 1'b0; cur.z = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_shift();
        test_enable_hold();
        test_reset_priority();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
